// File: rtl/cordic_sum_scheduler.sv
// cordic_sum_scheduler
// Host command front-end plus backend sequencer for the function-evaluation
// datapath. GO operand triples are queued in a small FIFO and issued one at
// a time to the evaluation unit; each evaluation result is then accumulated
// into a running sum through the shared FP adder. READ and CLEAR wait until
// all queued and in-flight work has drained.

module cordic_sum_scheduler #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int PTR_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      start,
    input  logic [N_WIDTH-1:0]        n,
    input  logic [FLT_DATA_WIDTH-1:0] x_one,
    input  logic [FLT_DATA_WIDTH-1:0] x_two,
    input  logic [FLT_DATA_WIDTH-1:0] x_three,
    output logic                      done,
    output logic [FLT_DATA_WIDTH-1:0] result,
    output logic                      ev_start,
    output logic [FLT_DATA_WIDTH-1:0] ev_x_one,
    output logic [FLT_DATA_WIDTH-1:0] ev_x_two,
    output logic [FLT_DATA_WIDTH-1:0] ev_x_three,
    input  logic                      ev_done,
    input  logic [FLT_DATA_WIDTH-1:0] ev_result,
    output logic                      add_start,
    output logic [FLT_DATA_WIDTH-1:0] add_a,
    output logic [FLT_DATA_WIDTH-1:0] add_b,
    input  logic                      add_done,
    input  logic [FLT_DATA_WIDTH-1:0] add_result
);

    localparam int TRIPLE_W = 3 * FLT_DATA_WIDTH;

    // Command encodings
    localparam logic [N_WIDTH-1:0] CMD_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] CMD_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] CMD_READ  = N_WIDTH'(2);

    // Command FSM states
    localparam logic [1:0] C_IDLE       = 2'd0;
    localparam logic [1:0] C_WAIT_SLOT  = 2'd1;
    localparam logic [1:0] C_WAIT_DRAIN = 2'd2;
    localparam logic [1:0] C_DONE       = 2'd3;

    // Backend FSM states
    localparam logic [1:0] B_IDLE = 2'd0;
    localparam logic [1:0] B_EVAL = 2'd1;
    localparam logic [1:0] B_ADD  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                r_cstate;
    logic [1:0]                r_bstate;
    logic [N_WIDTH-1:0]        r_cmd;
    logic [TRIPLE_W-1:0]       r_pend;
    logic [FLT_DATA_WIDTH-1:0] r_result;
    logic [FLT_DATA_WIDTH-1:0] r_sum;

    logic [TRIPLE_W-1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]      r_wr_ptr;
    logic [PTR_WIDTH-1:0]      r_rd_ptr;
    logic [PTR_WIDTH:0]        r_count;

    logic                      r_ev_start;
    logic                      r_add_start;
    logic [FLT_DATA_WIDTH-1:0] r_ev_x_one;
    logic [FLT_DATA_WIDTH-1:0] r_ev_x_two;
    logic [FLT_DATA_WIDTH-1:0] r_ev_x_three;
    logic [FLT_DATA_WIDTH-1:0] r_add_a;
    logic [FLT_DATA_WIDTH-1:0] r_add_b;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                      w_accept;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_drained;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_clear_now;
    logic [TRIPLE_W-1:0]       w_push_data;
    logic [PTR_WIDTH:0]        w_count_nxt;
    logic [FLT_DATA_WIDTH-1:0] w_count_ext;

    // Depth is a power of two, so the count MSB alone marks "full".
    assign w_full    = r_count[PTR_WIDTH];
    assign w_empty   = (r_count == '0);
    assign w_drained = w_empty && (r_bstate == B_IDLE);
    assign w_accept  = (r_cstate == C_IDLE) && start && clk_en;

    // Push decisions look only at the registered count, so a pop in the
    // same cycle as a full FIFO still defers a stalled GO by one cycle.
    assign w_push = (w_accept && (n == CMD_GO) && !w_full) ||
                    ((r_cstate == C_WAIT_SLOT) && !w_full);
    assign w_pop  = (r_bstate == B_IDLE) && !w_empty;

    assign w_push_data = (r_cstate == C_WAIT_SLOT) ? r_pend
                                                   : {x_one, x_two, x_three};

    // CLEAR only fires with the backend idle, so it never races the sum write.
    assign w_clear_now = (r_cstate == C_WAIT_DRAIN) && w_drained &&
                         (r_cmd == CMD_CLEAR);

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    assign w_count_ext = {{(FLT_DATA_WIDTH-PTR_WIDTH-1){1'b0}}, w_count_nxt};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Operand storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointers and occupancy; reset discards any queued triples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    // Accept one host command at a time and produce its done/result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cstate <= C_IDLE;
            r_cmd    <= '0;
            r_pend   <= '0;
            r_result <= '0;
        end else begin
            case (r_cstate)
                C_IDLE: begin
                    if (w_accept) begin
                        r_cmd <= n;
                        if (n == CMD_GO) begin
                            if (!w_full) begin
                                r_result <= w_count_ext;
                                r_cstate <= C_DONE;
                            end else begin
                                r_pend   <= {x_one, x_two, x_three};
                                r_cstate <= C_WAIT_SLOT;
                            end
                        end else if ((n == CMD_READ) || (n == CMD_CLEAR)) begin
                            r_cstate <= C_WAIT_DRAIN;
                        end else begin
                            // Reserved command: complete with no side effects.
                            r_result <= '0;
                            r_cstate <= C_DONE;
                        end
                    end
                end
                C_WAIT_SLOT: begin
                    if (!w_full) begin
                        r_result <= w_count_ext;
                        r_cstate <= C_DONE;
                    end
                end
                C_WAIT_DRAIN: begin
                    if (w_drained) begin
                        r_result <= (r_cmd == CMD_READ) ? r_sum : '0;
                        r_cstate <= C_DONE;
                    end
                end
                C_DONE: begin
                    r_cstate <= C_IDLE;
                end
                default: begin
                    r_cstate <= C_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Backend FSM
    // ------------------------------------------------------------------
    // Pop a triple, run it through the evaluator, then accumulate via adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bstate     <= B_IDLE;
            r_ev_start   <= 1'b0;
            r_add_start  <= 1'b0;
            r_ev_x_one   <= '0;
            r_ev_x_two   <= '0;
            r_ev_x_three <= '0;
            r_add_a      <= '0;
            r_add_b      <= '0;
        end else begin
            r_ev_start  <= 1'b0;
            r_add_start <= 1'b0;
            case (r_bstate)
                B_IDLE: begin
                    if (w_pop) begin
                        {r_ev_x_one, r_ev_x_two, r_ev_x_three} <= r_mem[r_rd_ptr];
                        r_ev_start <= 1'b1;
                        r_bstate   <= B_EVAL;
                    end
                end
                B_EVAL: begin
                    if (ev_done) begin
                        r_add_a     <= r_sum;
                        r_add_b     <= ev_result;
                        r_add_start <= 1'b1;
                        r_bstate    <= B_ADD;
                    end
                end
                B_ADD: begin
                    if (add_done) begin
                        r_bstate <= B_IDLE;
                    end
                end
                default: begin
                    r_bstate <= B_IDLE;
                end
            endcase
        end
    end

    // Running sum: cleared by CLEAR, otherwise loaded from the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_clear_now) begin
            r_sum <= '0;
        end else if ((r_bstate == B_ADD) && add_done) begin
            r_sum <= add_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign done       = (r_cstate == C_DONE);
    assign result     = r_result;
    assign ev_start   = r_ev_start;
    assign ev_x_one   = r_ev_x_one;
    assign ev_x_two   = r_ev_x_two;
    assign ev_x_three = r_ev_x_three;
    assign add_start  = r_add_start;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;

endmodule

// File: tb/tb_cordic_sum_scheduler.sv
// Directed bench for cordic_sum_scheduler. The evaluation unit is modelled
// as "return x_one after 3 cycles" (stallable), the adder as a real FP add
// taking 2 cycles.

module tb_cordic_sum_scheduler;

    localparam logic [1:0] CMD_CLEAR = 2'd0;
    localparam logic [1:0] CMD_GO    = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    localparam logic [31:0] F_1 = 32'h3F800000;
    localparam logic [31:0] F_2 = 32'h40000000;
    localparam logic [31:0] F_3 = 32'h40400000;
    localparam logic [31:0] F_4 = 32'h40800000;
    localparam logic [31:0] F_6 = 32'h40C00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start;
    logic [1:0]  n;
    logic [31:0] x_one, x_two, x_three;
    logic        done;
    logic [31:0] result;
    logic        ev_start;
    logic [31:0] ev_x_one, ev_x_two, ev_x_three;
    logic        ev_done;
    logic [31:0] ev_result;
    logic        add_start;
    logic [31:0] add_a, add_b;
    logic        add_done;
    logic [31:0] add_result;

    int total = 0;
    int bad   = 0;
    int add_cnt = 0;
    bit ev_stall = 1'b0;

    always #5 clk = ~clk;

    cordic_sum_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .start      (start),
        .n          (n),
        .x_one      (x_one),
        .x_two      (x_two),
        .x_three    (x_three),
        .done       (done),
        .result     (result),
        .ev_start   (ev_start),
        .ev_x_one   (ev_x_one),
        .ev_x_two   (ev_x_two),
        .ev_x_three (ev_x_three),
        .ev_done    (ev_done),
        .ev_result  (ev_result),
        .add_start  (add_start),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_done   (add_done),
        .add_result (add_result)
    );

    // Single-precision <-> real for normal numbers and zero.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Evaluation unit model: returns x_one three cycles after ev_start.
    logic [31:0] ev_lat;
    initial begin
        ev_done = 1'b0;
        ev_result = '0;
        forever begin
            @(posedge clk); #1;
            if (ev_start) begin
                ev_lat = ev_x_one;
                while (ev_stall) @(posedge clk);
                repeat (3) @(posedge clk);
                #1;
                ev_done = 1'b1;
                ev_result = ev_lat;
                @(posedge clk); #1;
                ev_done = 1'b0;
            end
        end
    end

    // Adder model: a + b two cycles after add_start.
    logic [31:0] add_lat;
    initial begin
        add_done = 1'b0;
        add_result = '0;
        forever begin
            @(posedge clk); #1;
            if (add_start) begin
                add_lat = r2f(f2r(add_a) + f2r(add_b));
                repeat (2) @(posedge clk);
                #1;
                add_done = 1'b1;
                add_result = add_lat;
                add_cnt++;
                @(posedge clk); #1;
                add_done = 1'b0;
            end
        end
    end

    // Issue one command and wait (bounded) for done; lat=-1 on timeout.
    task automatic do_cmd(input logic [1:0] cmd, input logic [31:0] a,
                          input int budget, output logic [31:0] res,
                          output int lat);
        @(posedge clk); #1;
        start = 1'b1; clk_en = 1'b1; n = cmd;
        x_one = a; x_two = 32'h0; x_three = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        res = 32'hDEADBEEF;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                res = result;
                lat = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] res;
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if (ev_start !== 1'b0 || add_start !== 1'b0) begin bad++; $display("FAIL reset_starts got=%b%b want=00", ev_start, add_start); end
        total++; if (ev_x_one !== 32'h0 || add_a !== 32'h0 || add_b !== 32'h0) begin bad++; $display("FAIL reset_operands got=%h/%h/%h want=0", ev_x_one, add_a, add_b); end
        rst = 1'b0;
        do_cmd(CMD_READ, 32'h0, 20, res, lat);
        total++; if (lat !== 1 || res !== 32'h0) begin bad++; $display("FAIL reset_read got lat=%0d res=%h want lat=1 res=0", lat, res); end
    endtask

    task automatic test_go_read();
        logic [31:0] res;
        int lat;
        int base;
        base = add_cnt;
        do_cmd(CMD_GO, F_1, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL go1 got lat=%0d res=%h want lat=0 res=1", lat, res); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL go1_done_width got=%b want=0", done); end
        do_cmd(CMD_GO, F_2, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL go2 got lat=%0d res=%h want lat=0 res=1", lat, res); end
        do_cmd(CMD_READ, 32'h0, 100, res, lat);
        total++; if (lat < 0 || res !== F_3) begin bad++; $display("FAIL read_sum3 got lat=%0d res=%h want=%h", lat, res, F_3); end
        total++; if (add_cnt - base !== 2) begin bad++; $display("FAIL read_after_adds got=%0d want=2", add_cnt - base); end
    endtask

    task automatic test_clear();
        logic [31:0] res;
        int lat;
        int base;
        base = add_cnt;
        do_cmd(CMD_GO, F_1, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL clr_go got lat=%0d res=%h want lat=0 res=1", lat, res); end
        do_cmd(CMD_CLEAR, 32'h0, 100, res, lat);
        total++; if (lat < 0 || res !== 32'h0 || add_cnt - base !== 1) begin bad++; $display("FAIL clear got lat=%0d res=%h adds=%0d want res=0 adds=1", lat, res, add_cnt - base); end
        do_cmd(CMD_READ, 32'h0, 20, res, lat);
        total++; if (lat !== 1 || res !== 32'h0) begin bad++; $display("FAIL read_after_clear got lat=%0d res=%h want lat=1 res=0", lat, res); end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        int exp_cnt [5] = '{1, 1, 2, 3, 4};
        bit early;
        ev_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_cmd(CMD_GO, F_1, 20, res, lat);
            total++; if (lat !== 0 || res !== 32'(exp_cnt[k])) begin bad++; $display("FAIL bp_go%0d got lat=%0d res=%h want lat=0 res=%0d", k, lat, res, exp_cnt[k]); end
        end
        // Sixth GO finds the FIFO full and must stall.
        @(posedge clk); #1;
        start = 1'b1; n = CMD_GO; x_one = F_1;
        @(posedge clk); #1;
        start = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) early = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL bp_stall got done=1 want no done while full"); end
        ev_stall = 1'b0;
        lat = -1;
        res = 32'hDEADBEEF;
        for (int i = 0; i < 100; i++) begin
            if (done) begin res = result; lat = i; break; end
            @(posedge clk); #1;
        end
        total++; if (lat < 0 || res !== 32'd4) begin bad++; $display("FAIL bp_go6 got lat=%0d res=%h want res=4", lat, res); end
        do_cmd(CMD_READ, 32'h0, 300, res, lat);
        total++; if (lat < 0 || res !== F_6) begin bad++; $display("FAIL bp_read got lat=%0d res=%h want=%h", lat, res, F_6); end
    endtask

    task automatic test_ignored();
        logic [31:0] res;
        int lat;
        bit seen;
        do_cmd(CMD_CLEAR, 32'h0, 300, res, lat);
        total++; if (lat < 0 || res !== 32'h0) begin bad++; $display("FAIL ign_clear got lat=%0d res=%h want res=0", lat, res); end
        // start without clk_en
        @(posedge clk); #1;
        clk_en = 1'b0; start = 1'b1; n = CMD_GO; x_one = F_1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin start = 1'b0; clk_en = 1'b1; end
            if (done || ev_start) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ign_clk_en got activity=1 want=0"); end
        // start while READ is draining
        ev_stall = 1'b1;
        do_cmd(CMD_GO, F_2, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL ign_go got lat=%0d res=%h want lat=0 res=1", lat, res); end
        @(posedge clk); #1;
        start = 1'b1; n = CMD_READ;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin start = 1'b1; n = CMD_GO; x_one = F_1; end
            if (i == 3) start = 1'b0;
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL ign_drain_done got done=1 want=0"); end
        ev_stall = 1'b0;
        lat = -1;
        res = 32'hDEADBEEF;
        for (int i = 0; i < 100; i++) begin
            if (done) begin res = result; lat = i; break; end
            @(posedge clk); #1;
        end
        total++; if (lat < 0 || res !== F_2) begin bad++; $display("FAIL ign_read got lat=%0d res=%h want=%h", lat, res, F_2); end
        do_cmd(CMD_GO, F_1, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL ign_count got lat=%0d res=%h want lat=0 res=1", lat, res); end
    endtask

    task automatic test_reset_in_add();
        logic [31:0] res;
        int lat;
        bit found;
        bit act;
        do_cmd(CMD_GO, F_4, 20, res, lat);
        total++; if (lat !== 0 || res !== 32'd1) begin bad++; $display("FAIL rst_go got lat=%0d res=%h want lat=0 res=1", lat, res); end
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (add_start) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_wait_add got timeout want add_start"); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ev_start || add_start || done) act = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (act !== 1'b0) begin bad++; $display("FAIL rst_quiet got activity=1 want=0"); end
        total++; if (ev_x_one !== 32'h0 || add_a !== 32'h0) begin bad++; $display("FAIL rst_ops got=%h/%h want=0", ev_x_one, add_a); end
        do_cmd(CMD_READ, 32'h0, 20, res, lat);
        total++; if (lat !== 1 || res !== 32'h0) begin bad++; $display("FAIL rst_read got lat=%0d res=%h want lat=1 res=0", lat, res); end
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; start = 1'b0; n = 2'd0;
        x_one = '0; x_two = '0; x_three = '0;
        test_reset();
        test_go_read();
        test_clear();
        test_backpressure();
        test_ignored();
        test_reset_in_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_sum_scheduler.md
# cordic_sum_scheduler

Command front-end and sequencer for the function-evaluation datapath. It accepts GO/READ/CLEAR custom-instruction commands from the host and buffers GO operand triples in a small FIFO. It issues each triple, one at a time, to the shared evaluation unit (start/done), then feeds each evaluation result and the running sum to the shared floating-point adder. It also serialises READ and CLEAR behind all outstanding work.

## Interface
Parameters:
- FLT_DATA_WIDTH, 32, operand/result/sum width (IEEE-754 single)
- N_WIDTH, 2, command field width
- FIFO_DEPTH, 4, queued GO triples (power of two)
- PTR_WIDTH, 2, log2(FIFO_DEPTH)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- clk_en  in  1  qualifies start; backend runs regardless
- start  in  1  command strobe, sampled only when clk_en=1
- n  in  N_WIDTH  command: 0 CLEAR, 1 GO, 2 READ, 3 reserved
- x_one, x_two, x_three  in  FLT_DATA_WIDTH  GO operands
- done  out  1  one-cycle command-complete pulse
- result  out  FLT_DATA_WIDTH  command return value, valid while done=1
- ev_start  out  1  one-cycle start to evaluation unit
- ev_x_one, ev_x_two, ev_x_three  out  FLT_DATA_WIDTH  operands to evaluation unit, held until ev_done
- ev_done  in  1  evaluation-complete pulse
- ev_result  in  FLT_DATA_WIDTH  evaluation result, valid with ev_done
- add_start  out  1  one-cycle start to FP adder
- add_a, add_b  out  FLT_DATA_WIDTH  adder operands (sum, evaluation result), held until add_done
- add_done  in  1  adder-complete pulse
- add_result  in  FLT_DATA_WIDTH  adder result, valid with add_done

## Operation
- Reset values: done=0, result=0, ev_start=0, add_start=0, all ev_x/add operand regs=0, sum=0, FIFO count/pointers=0. Both FSMs go to IDLE. Reset mid-operation discards queued and in-flight work. A late ev_done/add_done after reset is ignored because the backend is in B_IDLE.
- Command FSM states: C_IDLE, C_WAIT_SLOT, C_WAIT_DRAIN, C_DONE.
  - In C_IDLE, a command is accepted when start and clk_en are both 1. start in any other state is ignored, so there is no queuing of commands.
  - GO: if count<FIFO_DEPTH, push {x_one,x_two,x_three} and go to C_DONE with result = count after push (zero-extended). If the FIFO is full, go to C_WAIT_SLOT, which latches the operands and pushes on the first cycle count<FIFO_DEPTH.
  - READ: go to C_WAIT_DRAIN. When count=0 and the backend is in B_IDLE, set result=sum and go to C_DONE.
  - CLEAR: go to C_WAIT_DRAIN. When drained, set sum=0 and result=0, then go to C_DONE.
  - n=3: go to C_DONE with result=0 and no side effects.
  - C_DONE: done=1 for exactly one cycle, then C_IDLE.
- Backend FSM states: B_IDLE, B_EVAL, B_ADD.
  - B_IDLE with count>0: pop the head into ev_x_*, pulse ev_start, go to B_EVAL.
  - B_EVAL on ev_done: add_a=sum, add_b=ev_result, pulse add_start, go to B_ADD.
  - B_ADD on add_done: sum=add_result, go to B_IDLE.
- Push and pop in the same cycle is allowed: count is unchanged. A full FIFO with a pop in the same cycle still defers the push by one cycle (the push decision uses registered count).
- Results accumulate in FIFO order. sum is never written by more than one source in a cycle, because CLEAR only acts while the backend is in B_IDLE.

## Timing
- GO with space: start sampled at edge T; done=1 during cycle T+1 (commands are 2 cycles start-to-idle). A subsequent command can be accepted at edge T+2.
- Backend latency per triple: 1 cycle (pop/ev_start) + evaluation latency + 1 cycle (add_start) + adder latency + 1 cycle (sum write). B_IDLE can issue the next triple on the cycle after the sum write.
- READ/CLEAR latency: drain time + 1 cycle to C_DONE. With an empty, idle backend, done is in cycle T+2.
- ev_start and add_start are never high for more than one cycle and never both high in the same cycle.
- result holds its last value outside done. Only the done cycle is meaningful.

## Test plan
- Reset then READ (bench models: eval returns x_one after 3 cycles, adder is a real FP add taking 2 cycles) -> done pulse, result=32'h00000000.
- GO x_one=32'h3F800000 (1.0), then GO x_one=32'h40000000 (2.0), then READ -> GO results 1 and 1 or 2 depending on drain, READ result=32'h40400000 (3.0); READ done only after the second add_done.
- Stall eval unit (no ev_done); issue 5 GOs -> GO results 1,2,3,4 (first pop empties one slot, so results are 1,1,2,3,4 shape checked against count model); 6th GO stays in C_WAIT_SLOT with no done until ev_done releases a slot.
- CLEAR after GO 1.0 -> waits for add_done, done pulse with result=0; next READ returns 0.
- start with clk_en=0, and start during C_WAIT_DRAIN -> ignored, no done, FIFO count unchanged.
- Assert rst while in B_ADD, then pulse add_done -> sum stays 0, ev_start/add_start stay 0, READ returns 0.
